// File: rtl/virtual_ds2431_pkg.sv
// Shared definitions for the virtual DS2431 memory-function layer: command codes,
// handler indices, dispatcher state encoding and the command decoder.
package virtual_ds2431_pkg;

  localparam logic [7:0] CMD_WRITE_SP = 8'h0F;
  localparam logic [7:0] CMD_READ_SP  = 8'hAA;
  localparam logic [7:0] CMD_COPY_SP  = 8'h55;
  localparam logic [7:0] CMD_READ_MEM = 8'hF0;

  localparam logic [1:0] HDL_WRITE_SP = 2'd0;
  localparam logic [1:0] HDL_READ_SP  = 2'd1;
  localparam logic [1:0] HDL_COPY_SP  = 2'd2;
  localparam logic [1:0] HDL_READ_MEM = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RX_CMD = 3'd1,
    ST_RX_TA1 = 3'd2,
    ST_RX_TA2 = 3'd3,
    ST_RUN    = 3'd4,
    ST_HALT   = 3'd5
  } ds_state_e;

  typedef struct packed {
    logic       valid;
    logic       has_ta;
    logic [1:0] idx;
  } cmd_dec_t;

  // Commands that address memory carry TA1/TA2; the others collect their own bytes.
  function automatic cmd_dec_t decode_cmd(input logic [7:0] code);
    cmd_dec_t d;
    d = '{valid: 1'b0, has_ta: 1'b0, idx: HDL_WRITE_SP};
    case (code)
      CMD_WRITE_SP: d = '{valid: 1'b1, has_ta: 1'b1, idx: HDL_WRITE_SP};
      CMD_READ_SP:  d = '{valid: 1'b1, has_ta: 1'b0, idx: HDL_READ_SP};
      CMD_COPY_SP:  d = '{valid: 1'b1, has_ta: 1'b0, idx: HDL_COPY_SP};
      CMD_READ_MEM: d = '{valid: 1'b1, has_ta: 1'b1, idx: HDL_READ_MEM};
      default:      d = '{valid: 1'b0, has_ta: 1'b0, idx: HDL_WRITE_SP};
    endcase
    return d;
  endfunction

  function automatic logic [3:0] hdl_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/virtual_ds2431_edge_det.sv
// Resettable rising-edge detector: one-cycle pulse when sig_i goes 0->1.
// The history flop clears on reset so a stale level never looks like a new edge.
module virtual_ds2431_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic rise_o
);

  logic prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= sig_i;
    end
  end

  assign rise_o = sig_i & ~prev_q;

endmodule

// File: rtl/virtual_ds2431_mem_cmd_dispatch.sv
// Memory-function dispatcher: receives command (+TA1/TA2), runs one handler on the shared
// byte transport, then parks in HALT. Optional handler watchdog: DS2431_DISPATCH_WDT_EN.
module virtual_ds2431_mem_cmd_dispatch
  import virtual_ds2431_pkg::*;
#(
  parameter logic [23:0] WDT_CYCLES = 24'd4_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memFuncEn,
  input  logic        owResetPulse,
  input  logic [7:0]  rxDat,
  input  logic        ByteTransDone,
  output logic [7:0]  txDat,
  output logic        nRxTx,
  output logic        transTrig,
  output logic [7:0]  TA1,
  output logic [7:0]  TA2,
  output logic [3:0]  hdlRun,
  input  logic [3:0]  hdlDone,
  input  logic [31:0] hdlTxDat,
  input  logic [3:0]  hdlNRxTx,
  input  logic [3:0]  hdlTransTrig,
  output logic [3:0]  hdlByteDone,
  output logic        busy,
  output logic        cmdErr,
  output logic [2:0]  dbgState
);

  ds_state_e  state_q;
  logic       trig_q;
  logic [7:0] ta1_q;
  logic [7:0] ta2_q;
  logic [3:0] hdl_run_q;
  logic [1:0] sel_q;
  logic       cmd_err_q;

  logic       mfe_edge;
  logic       bt_edge;
  logic       done_edge;
  logic       done_sel;
  logic       abort;
  logic       wdt_hit;
  cmd_dec_t   cmd_dec;

  virtual_ds2431_edge_det u_mfe_edge (
    .clk    (clk),
    .rst    (rst),
    .sig_i  (memFuncEn),
    .rise_o (mfe_edge)
  );

  virtual_ds2431_edge_det u_bt_edge (
    .clk    (clk),
    .rst    (rst),
    .sig_i  (ByteTransDone),
    .rise_o (bt_edge)
  );

  assign done_sel = hdlDone[sel_q];

  virtual_ds2431_edge_det u_done_edge (
    .clk    (clk),
    .rst    (rst),
    .sig_i  (done_sel),
    .rise_o (done_edge)
  );

  assign cmd_dec = decode_cmd(rxDat);

  // A 1-Wire reset, or losing the memory-function phase, beats every other event.
  assign abort = owResetPulse | (~memFuncEn & (state_q != ST_IDLE));

`ifdef DS2431_DISPATCH_WDT_EN
  logic [23:0] wdt_q;
  logic [23:0] wdt_d;

  always_comb begin
    wdt_d = wdt_q + 24'd1;
    if ((state_q != ST_RUN) || bt_edge) begin
      wdt_d = 24'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdt_q <= 24'd0;
    end else begin
      wdt_q <= wdt_d;
    end
  end

  assign wdt_hit = (state_q == ST_RUN) && (wdt_q == (WDT_CYCLES - 24'd1));
`else
  // Watchdog compiled out: RUN ends only on handler done or abort.
  assign wdt_hit = (WDT_CYCLES == 24'd0) & 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      trig_q    <= 1'b0;
      ta1_q     <= 8'h00;
      ta2_q     <= 8'h00;
      hdl_run_q <= 4'b0000;
      sel_q     <= 2'd0;
      cmd_err_q <= 1'b0;
    end else begin
      trig_q <= 1'b0;
      if (abort) begin
        state_q   <= ST_IDLE;
        hdl_run_q <= 4'b0000;
        cmd_err_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (mfe_edge) begin
              state_q <= ST_RX_CMD;
              trig_q  <= 1'b1;
            end
          end
          ST_RX_CMD: begin
            if (bt_edge) begin
              sel_q <= cmd_dec.idx;
              if (!cmd_dec.valid) begin
                state_q   <= ST_HALT;
                cmd_err_q <= 1'b1;
              end else if (cmd_dec.has_ta) begin
                state_q <= ST_RX_TA1;
                trig_q  <= 1'b1;
              end else begin
                state_q   <= ST_RUN;
                hdl_run_q <= hdl_onehot(cmd_dec.idx);
              end
            end
          end
          ST_RX_TA1: begin
            if (bt_edge) begin
              ta1_q   <= rxDat;
              state_q <= ST_RX_TA2;
              trig_q  <= 1'b1;
            end
          end
          ST_RX_TA2: begin
            if (bt_edge) begin
              ta2_q     <= rxDat;
              state_q   <= ST_RUN;
              hdl_run_q <= hdl_onehot(sel_q);
            end
          end
          ST_RUN: begin
            if (done_edge) begin
              state_q   <= ST_HALT;
              hdl_run_q <= 4'b0000;
            end else if (wdt_hit) begin
              state_q   <= ST_HALT;
              hdl_run_q <= 4'b0000;
              cmd_err_q <= 1'b1;
            end
          end
          ST_HALT: begin
            state_q <= ST_HALT;
          end
          default: begin
            state_q   <= ST_IDLE;
            hdl_run_q <= 4'b0000;
          end
        endcase
      end
    end
  end

  // Transport belongs to the selected handler only while in RUN.
  always_comb begin
    txDat       = 8'hFF;
    nRxTx       = 1'b0;
    transTrig   = trig_q;
    hdlByteDone = 4'b0000;
    if (state_q == ST_RUN) begin
      txDat       = hdlTxDat[{sel_q, 3'b000} +: 8];
      nRxTx       = hdlNRxTx[sel_q];
      transTrig   = hdlTransTrig[sel_q];
      hdlByteDone = hdl_onehot(sel_q) & {4{ByteTransDone}};
    end
    if (abort) begin
      transTrig = 1'b0;
    end
  end

  assign TA1      = ta1_q;
  assign TA2      = ta2_q;
  assign hdlRun   = hdl_run_q;
  assign busy     = (state_q != ST_IDLE);
  assign cmdErr   = cmd_err_q;
  assign dbgState = state_q;

endmodule

// File: tb/tb_virtual_ds2431_mem_cmd_dispatch.sv
// Directed bench for the memory-function dispatcher with a transaction-level expectation model.
module tb_virtual_ds2431_mem_cmd_dispatch;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic        memFuncEn, owResetPulse, ByteTransDone;
  logic [7:0]  rxDat;
  logic [7:0]  txDat, TA1, TA2;
  logic        nRxTx, transTrig, busy, cmdErr;
  logic [3:0]  hdlRun, hdlDone, hdlNRxTx, hdlTransTrig, hdlByteDone;
  logic [31:0] hdlTxDat;
  logic [2:0]  dbgState;

  virtual_ds2431_mem_cmd_dispatch #(.WDT_CYCLES(24'd100)) dut (
    .clk          (clk),
    .rst          (rst),
    .memFuncEn    (memFuncEn),
    .owResetPulse (owResetPulse),
    .rxDat        (rxDat),
    .ByteTransDone(ByteTransDone),
    .txDat        (txDat),
    .nRxTx        (nRxTx),
    .transTrig    (transTrig),
    .TA1          (TA1),
    .TA2          (TA2),
    .hdlRun       (hdlRun),
    .hdlDone      (hdlDone),
    .hdlTxDat     (hdlTxDat),
    .hdlNRxTx     (hdlNRxTx),
    .hdlTransTrig (hdlTransTrig),
    .hdlByteDone  (hdlByteDone),
    .busy         (busy),
    .cmdErr       (cmdErr),
    .dbgState     (dbgState)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- expectation model ----------------
  typedef enum int {P_IDLE, P_CMD, P_TA1, P_TA2, P_RUN, P_HALT} phase_e;
  phase_e     m_phase = P_IDLE;
  int         m_sel   = 0;
  logic       m_trig  = 1'b0;
  logic       m_err   = 1'b0;
  logic [7:0] m_ta1   = 8'h00;
  logic [7:0] m_ta2   = 8'h00;
  logic       chk_en  = 1'b0;
  int         trig_cnt = 0;

  // Entering any byte-receive phase starts exactly one transport byte.
  function automatic void m_goto(input phase_e p);
    m_phase = p;
    m_trig  = (p == P_CMD) || (p == P_TA1) || (p == P_TA2);
  endfunction

  function automatic void m_rx(input logic [7:0] b);
    case (m_phase)
      P_CMD: begin
        case (b)
          8'h0F:   begin m_sel = 0; m_goto(P_TA1); end
          8'hAA:   begin m_sel = 1; m_goto(P_RUN); end
          8'h55:   begin m_sel = 2; m_goto(P_RUN); end
          8'hF0:   begin m_sel = 3; m_goto(P_TA1); end
          default: begin m_sel = 0; m_err = 1'b1; m_goto(P_HALT); end
        endcase
      end
      P_TA1:   begin m_ta1 = b; m_goto(P_TA2); end
      P_TA2:   begin m_ta2 = b; m_goto(P_RUN); end
      default: ;
    endcase
  endfunction

  function automatic void m_abort();
    m_err = 1'b0;
    m_goto(P_IDLE);
  endfunction

  // ---------------- per-cycle compare ----------------
  logic       c_ab, c_tt, c_dir;
  logic [7:0] c_tx;
  logic [3:0] c_bd, c_run;

  always @(negedge clk) begin
    if (chk_en) begin
      c_ab = owResetPulse || (!memFuncEn && (m_phase != P_IDLE));
      if (m_phase == P_RUN) begin
        c_tx  = hdlTxDat[m_sel*8 +: 8];
        c_dir = hdlNRxTx[m_sel];
        c_tt  = hdlTransTrig[m_sel];
        c_run = 4'b0001 << m_sel;
        c_bd  = ByteTransDone ? c_run : 4'b0000;
      end else begin
        c_tx  = 8'hFF;
        c_dir = 1'b0;
        c_tt  = m_trig;
        c_run = 4'b0000;
        c_bd  = 4'b0000;
      end
      if (c_ab) c_tt = 1'b0;
      check("txDat", txDat, c_tx);
      check("nRxTx", nRxTx, c_dir);
      check("transTrig", transTrig, c_tt);
      check("hdlByteDone", hdlByteDone, c_bd);
      check("hdlRun", hdlRun, c_run);
      check("busy", busy, m_phase != P_IDLE);
      check("cmdErr", cmdErr, m_err);
      check("TA1", TA1, m_ta1);
      check("TA2", TA2, m_ta2);
      if (transTrig && m_phase != P_RUN) trig_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
    m_trig = 1'b0;
  endtask

  task automatic start_cmd();
    step();
    memFuncEn = 1'b0;
    step();
    memFuncEn = 1'b1;
    step();
    m_goto(P_CMD);
  endtask

  // Transport delivers byte b; returns just after the dispatcher has reacted.
  task automatic rx_byte(input logic [7:0] b);
    step();
    rxDat = b;
    ByteTransDone = 1'b1;
    step();
    ByteTransDone = 1'b0;
    m_rx(b);
  endtask

  task automatic ow_reset();
    owResetPulse = 1'b1;
    step();
    owResetPulse = 1'b0;
    m_abort();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    memFuncEn = 1'b0; owResetPulse = 1'b0; ByteTransDone = 1'b0; rxDat = 8'h00;
    hdlDone = 4'b0; hdlTxDat = 32'h0; hdlNRxTx = 4'b0; hdlTransTrig = 4'b0;
    repeat (2) @(negedge clk);
    check("rst_txDat", txDat, 8'hFF);
    check("rst_nRxTx", nRxTx, 1'b0);
    check("rst_transTrig", transTrig, 1'b0);
    check("rst_TA1", TA1, 8'h00);
    check("rst_TA2", TA2, 8'h00);
    check("rst_hdlRun", hdlRun, 4'b0000);
    check("rst_hdlByteDone", hdlByteDone, 4'b0000);
    check("rst_busy", busy, 1'b0);
    check("rst_cmdErr", cmdErr, 1'b0);
    step();
    rst = 1'b0;
    chk_en = 1'b1;

    // ReadMemory with target address, then handler owns transport
    start_cmd();
    trig_cnt = 0;
    rx_byte(8'hF0);
    rx_byte(8'h10);
    rx_byte(8'h00);
    @(negedge clk);
    check("rm_TA1", TA1, 8'h10);
    check("rm_TA2", TA2, 8'h00);
    check("rm_hdlRun", hdlRun, 4'b1000);
    check("rm_trig_count", trig_cnt, 3);
    step();
    hdlTxDat = {8'hA5, 8'h33, 8'h22, 8'h11};
    hdlNRxTx = 4'b1000;
    hdlTransTrig = 4'b1000;
    @(negedge clk);
    check("rm_txDat", txDat, 8'hA5);
    check("rm_nRxTx", nRxTx, 1'b1);
    check("rm_transTrig", transTrig, 1'b1);
    step();
    hdlNRxTx = 4'b0111;
    hdlTransTrig = 4'b0111;
    step();
    ByteTransDone = 1'b1;
    @(negedge clk);
    check("rm_hdlByteDone", hdlByteDone, 4'b1000);
    step();
    ByteTransDone = 1'b0;
    hdlTransTrig = 4'b0000;
    hdlDone = 4'b1000;
    step();
    m_goto(P_HALT);
    hdlDone = 4'b0000;
    step();
    memFuncEn = 1'b0;
    step();
    m_abort();

    // ReadScratchpad: one byte, done coincident with a byte edge
    start_cmd();
    rx_byte(8'hAA);
    @(negedge clk);
    check("rs_hdlRun", hdlRun, 4'b0010);
    check("rs_TA1_kept", TA1, 8'h10);
    step();
    hdlDone = 4'b0010;
    ByteTransDone = 1'b1;
    @(negedge clk);
    check("rs_coincident_bytedone", hdlByteDone, 4'b0010);
    step();
    m_goto(P_HALT);
    hdlDone = 4'b0000;
    ByteTransDone = 1'b0;
    @(negedge clk);
    check("rs_halt_hdlRun", hdlRun, 4'b0000);
    check("rs_halt_busy", busy, 1'b1);
    step();
    ow_reset();

    // Unknown command -> HALT with error, cleared by 1-Wire reset
    start_cmd();
    rx_byte(8'h33);
    @(negedge clk);
    check("bad_cmdErr", cmdErr, 1'b1);
    check("bad_hdlRun", hdlRun, 4'b0000);
    step();
    ow_reset();
    @(negedge clk);
    check("bad_cleared_cmdErr", cmdErr, 1'b0);
    check("bad_cleared_busy", busy, 1'b0);

    // 1-Wire reset in the very cycle RX_TA2 would start its byte
    start_cmd();
    rx_byte(8'h0F);
    rx_byte(8'h22);
    owResetPulse = 1'b1;
    @(negedge clk);
    check("ta2_abort_trig", transTrig, 1'b0);
    step();
    owResetPulse = 1'b0;
    m_abort();
    @(negedge clk);
    check("ta2_abort_busy", busy, 1'b0);
    check("ta2_abort_TA1", TA1, 8'h22);

    // 1-Wire reset during RUN
    start_cmd();
    rx_byte(8'h55);
    repeat (3) step();
    ow_reset();
    @(negedge clk);
    check("run_abort_hdlRun", hdlRun, 4'b0000);

    // memFuncEn dropping mid-command
    start_cmd();
    rx_byte(8'hF0);
    memFuncEn = 1'b0;
    step();
    m_abort();
    @(negedge clk);
    check("mfe_drop_busy", busy, 1'b0);

    // Handler that never finishes
    start_cmd();
    rx_byte(8'h0F);
    rx_byte(8'h01);
    rx_byte(8'h02);
`ifdef DS2431_DISPATCH_WDT_EN
    repeat (99) step();
    @(negedge clk);
    check("wdt_still_run", hdlRun, 4'b0001);
    step();
    m_err = 1'b1;
    m_goto(P_HALT);
    @(negedge clk);
    check("wdt_cmdErr", cmdErr, 1'b1);
    check("wdt_hdlRun", hdlRun, 4'b0000);
`else
    repeat (150) step();
    @(negedge clk);
    check("nowdt_hdlRun", hdlRun, 4'b0001);
    check("nowdt_cmdErr", cmdErr, 1'b0);
`endif
    step();
    ow_reset();

    // Asynchronous reset mid-RUN
    start_cmd();
    rx_byte(8'hAA);
    step();
    chk_en = 1'b0;
    rst = 1'b1;
    memFuncEn = 1'b0;
    #1;
    check("arst_hdlRun", hdlRun, 4'b0000);
    check("arst_busy", busy, 1'b0);
    check("arst_TA1", TA1, 8'h00);
    check("arst_txDat", txDat, 8'hFF);
    step();
    rst = 1'b0;
    m_abort();
    m_sel = 0;
    m_ta1 = 8'h00;
    m_ta2 = 8'h00;
    chk_en = 1'b1;
    repeat (3) step();
    @(negedge clk);
    check("post_rst_busy", busy, 1'b0);

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
